// File: rtl/fifo_param_pkg.sv
// fifo_param_pkg: width helpers, modulo pointer step and parameter legality for fifo_param.
package fifo_param_pkg;

    function automatic int ptr_width(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return ptr_width(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic bit params_ok(input int width, input int depth, input int af, input int ae);
        return width >= 1 && depth >= 2 && af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
    endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// fifo_param_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
module fifo_param_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised first-word-fall-through FIFO with count and almost flags.
// Define FIFO_PARAM_ERR_EN to build the sticky overflow/underflow flags and in_clear_err.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_write_ctrl,
    input  logic [WIDTH-1:0]           in_write_data,
    input  logic                       in_read_ctrl,
    input  logic                       in_clear_err,
    output logic [WIDTH-1:0]           out_read_data,
    output logic                       out_is_full,
    output logic                       out_is_empty,
    output logic                       out_almost_full,
    output logic                       out_almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] out_count,
    output logic                       out_overflow,
    output logic                       out_underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push_ok, pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign push_ok = in_write_ctrl & (~full | in_read_ctrl);
    assign pop_ok  = in_read_ctrl & ~empty;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= PW'(next_ptr(int'(wr_ptr), DEPTH));
            if (pop_ok) rd_ptr <= PW'(next_ptr(int'(rd_ptr), DEPTH));
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end

    fifo_param_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (in_write_data),
        .raddr (rd_ptr),
        .rdata (out_read_data)
    );

    assign out_is_full      = full;
    assign out_is_empty     = empty;
    assign out_almost_full  = count >= CW'(AF_LEVEL);
    assign out_almost_empty = count <= CW'(AE_LEVEL);
    assign out_count        = count;

`ifdef FIFO_PARAM_ERR_EN
    // A new violation outranks a clear arriving on the same edge.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            out_overflow  <= (in_write_ctrl & full & ~in_read_ctrl) | (out_overflow & ~in_clear_err);
            out_underflow <= (in_read_ctrl & empty) | (out_underflow & ~in_clear_err);
        end
`else
    logic unused_clear;
    assign unused_clear  = in_clear_err;
    assign out_overflow  = 1'b0;
    assign out_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: three FIFO configurations driven in lockstep and checked against queue models.
`define MSTEP(Q, D, O, U) \
    begin \
        if (w && Q.size() == D && !r) O = 1'b1; else if (c) O = 1'b0; \
        if (r && Q.size() == 0) U = 1'b1; else if (c) U = 1'b0; \
        if (r && Q.size() != 0) begin void'(Q.pop_front()); if (w) Q.push_back(d); end \
        else if (w && Q.size() < D) Q.push_back(d); \
    end

module tb_fifo_param;

`ifdef FIFO_PARAM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        wr = 1'b0, rdq = 1'b0, clr = 1'b0;
    logic [15:0] wd = '0;

    logic [7:0]  rd4, rd3;
    logic [15:0] rd5;
    logic [2:0]  cnt4, cnt5;
    logic [1:0]  cnt3;
    logic full4, empty4, af4, ae4, ov4, un4;
    logic full5, empty5, af5, ae5, ov5, un5;
    logic full3, empty3, af3, ae3, ov3, un3;

    logic [15:0] q4[$], q5[$], q3[$];
    bit mo4, mu4, mo5, mu5, mo3, mu3;
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(8), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .in_write_ctrl(wr), .in_write_data(wd[7:0]), .in_read_ctrl(rdq),
        .in_clear_err(clr), .out_read_data(rd4), .out_is_full(full4), .out_is_empty(empty4),
        .out_almost_full(af4), .out_almost_empty(ae4), .out_count(cnt4),
        .out_overflow(ov4), .out_underflow(un4));

    fifo_param #(.WIDTH(16), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .in_write_ctrl(wr), .in_write_data(wd), .in_read_ctrl(rdq),
        .in_clear_err(clr), .out_read_data(rd5), .out_is_full(full5), .out_is_empty(empty5),
        .out_almost_full(af5), .out_almost_empty(ae5), .out_count(cnt5),
        .out_overflow(ov5), .out_underflow(un5));

    fifo_param #(.WIDTH(8), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .in_write_ctrl(wr), .in_write_data(wd[7:0]), .in_read_ctrl(rdq),
        .in_clear_err(clr), .out_read_data(rd3), .out_is_full(full3), .out_is_empty(empty3),
        .out_almost_full(af3), .out_almost_empty(ae3), .out_count(cnt3),
        .out_overflow(ov3), .out_underflow(un3));

    task automatic model_reset();
        q4.delete(); q5.delete(); q3.delete();
        {mo4, mu4, mo5, mu5, mo3, mu3} = '0;
    endtask

    task automatic cycle(input bit w, input bit r, input logic [15:0] d, input bit c);
        wr = w; rdq = r; wd = d; clr = c;
        @(posedge clk);
        `MSTEP(q4, 4, mo4, mu4)
        `MSTEP(q5, 5, mo5, mu5)
        `MSTEP(q3, 3, mo3, mu3)
        #1;
        wr = 1'b0; rdq = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (empty4 !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b want=1", empty4); end
        checks++; if (ae4 !== 1'b1) begin errs++; $display("FAIL reset_almost_empty got=%b want=1", ae4); end
        checks++; if (full4 !== 1'b0 || af4 !== 1'b0) begin errs++; $display("FAIL reset_full got=%b%b want=00", full4, af4); end
        checks++; if (cnt4 !== 3'd0) begin errs++; $display("FAIL reset_count got=%0d want=0", cnt4); end
        checks++; if ({ov4, un4} !== 2'b00) begin errs++; $display("FAIL reset_errors got=%b want=00", {ov4, un4}); end
        checks++; if (cnt5 !== 3'd0 || cnt3 !== 2'd0) begin errs++; $display("FAIL reset_count_others got=%0d/%0d want=0/0", cnt5, cnt3); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b0, 16'(i), 1'b0);
            checks++; if (cnt5 !== 3'(i)) begin errs++; $display("FAIL fill5_count got=%0d want=%0d", cnt5, i); end
            checks++; if (af5 !== (i >= 4)) begin errs++; $display("FAIL fill5_almost_full push=%0d got=%b want=%b", i, af5, i >= 4); end
            checks++; if (full5 !== (i == 5)) begin errs++; $display("FAIL fill5_full push=%0d got=%b want=%b", i, full5, i == 5); end
        end
        checks++; if (ov4 !== ERR) begin errs++; $display("FAIL fill_overflow4 got=%b want=%b", ov4, ERR); end
        for (int i = 1; i <= 5; i++) begin
            checks++; if (rd5 !== 16'(i)) begin errs++; $display("FAIL drain5_data got=%h want=%h", rd5, 16'(i)); end
            cycle(1'b0, 1'b1, 16'h0, 1'b0);
        end
        checks++; if (empty5 !== 1'b1 || cnt5 !== 3'd0) begin errs++; $display("FAIL drain5_empty got=%b/%0d want=1/0", empty5, cnt5); end
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_wrap();
        for (int v = 0; v < 10; v++) begin
            cycle(1'b1, 1'b0, 16'(v), 1'b0);
            checks++; if (rd3 !== 8'(v) || cnt3 !== 2'd1) begin errs++; $display("FAIL wrap3 round=%0d got=%h/%0d want=%h/1", v, rd3, cnt3, 8'(v)); end
            cycle(1'b0, 1'b1, 16'h0, 1'b0);
            checks++; if (cnt3 !== 2'd0) begin errs++; $display("FAIL wrap3_pop round=%0d got=%0d want=0", v, cnt3); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4];
        exp = '{8'h0B, 8'h0C, 8'h0D, 8'h0E};
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'(8'h0A + i), 1'b0);
        checks++; if (full4 !== 1'b1 || cnt4 !== 3'd4 || rd4 !== 8'h0A) begin errs++; $display("FAIL full4 got=%b/%0d/%h want=1/4/0a", full4, cnt4, rd4); end
        cycle(1'b1, 1'b1, 16'h000E, 1'b0);
        checks++; if (full4 !== 1'b1 || cnt4 !== 3'd4) begin errs++; $display("FAIL full4_pushpop got=%b/%0d want=1/4", full4, cnt4); end
        checks++; if (ov4 !== 1'b0) begin errs++; $display("FAIL full4_pushpop_overflow got=%b want=0", ov4); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd4 !== exp[i]) begin errs++; $display("FAIL full4_order idx=%0d got=%h want=%h", i, rd4, exp[i]); end
            cycle(1'b0, 1'b1, 16'h0, 1'b0);
        end
        checks++; if (empty4 !== 1'b1) begin errs++; $display("FAIL full4_drained got=%b want=1", empty4); end
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'(8'h20 + i), 1'b0);
        cycle(1'b1, 1'b0, 16'h0099, 1'b0);
        checks++; if (cnt4 !== 3'd4 || rd4 !== 8'h20) begin errs++; $display("FAIL overflow_drop got=%0d/%h want=4/20", cnt4, rd4); end
        checks++; if (ov4 !== ERR) begin errs++; $display("FAIL overflow_flag got=%b want=%b", ov4, ERR); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd4 !== 8'(8'h20 + i)) begin errs++; $display("FAIL overflow_order idx=%0d got=%h want=%h", i, rd4, 8'(8'h20 + i)); end
            cycle(1'b0, 1'b1, 16'h0, 1'b0);
        end
        cycle(1'b0, 1'b1, 16'h0, 1'b0);
        checks++; if (un4 !== ERR || cnt4 !== 3'd0) begin errs++; $display("FAIL underflow got=%b/%0d want=%b/0", un4, cnt4, ERR); end
        checks++; if (ov4 !== ERR) begin errs++; $display("FAIL overflow_sticky got=%b want=%b", ov4, ERR); end
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        checks++; if ({ov4, un4} !== 2'b00) begin errs++; $display("FAIL clear_err got=%b want=00", {ov4, un4}); end
        cycle(1'b0, 1'b1, 16'h0, 1'b1);
        checks++; if (un4 !== ERR) begin errs++; $display("FAIL set_beats_clear got=%b want=%b", un4, ERR); end
        cycle(1'b1, 1'b1, 16'h0077, 1'b1);
        checks++; if (un4 !== ERR || cnt4 !== 3'd1 || rd4 !== 8'h77) begin errs++; $display("FAIL empty_pushpop got=%b/%0d/%h want=%b/1/77", un4, cnt4, rd4, ERR); end
        cycle(1'b0, 1'b1, 16'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'(8'h40 + i), 1'b0);
        checks++; if (cnt4 !== 3'd3) begin errs++; $display("FAIL pre_reset_count got=%0d want=3", cnt4); end
        #2 rst = 1'b1;
        #1;
        checks++; if (cnt4 !== 3'd0 || empty4 !== 1'b1 || ae4 !== 1'b1 || full4 !== 1'b0) begin
            errs++; $display("FAIL async_reset got=%0d/%b/%b/%b want=0/1/1/0", cnt4, empty4, ae4, full4); end
        model_reset();
        #2 rst = 1'b0;
        cycle(1'b1, 1'b0, 16'h005A, 1'b0);
        checks++; if (rd4 !== 8'h5A || cnt4 !== 3'd1) begin errs++; $display("FAIL after_reset_head got=%h/%0d want=5a/1", rd4, cnt4); end
        cycle(1'b0, 1'b1, 16'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit w, r, c;
            w = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            r = (n < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
            c = $urandom_range(0, 15) == 0;
            cycle(w, r, 16'($urandom), c);
            checks++; if (cnt4 !== 3'(q4.size()) || {full4, empty4, af4, ae4, ov4, un4} !== {q4.size() == 4, q4.size() == 0, q4.size() >= 3, q4.size() <= 1, ERR & mo4, ERR & mu4}) begin
                errs++; $display("FAIL rand4 n=%0d got=%0d/%b want=%0d", n, cnt4, {full4, empty4, af4, ae4, ov4, un4}, q4.size()); end
            checks++; if (cnt5 !== 3'(q5.size()) || {full5, empty5, af5, ae5, ov5, un5} !== {q5.size() == 5, q5.size() == 0, q5.size() >= 4, q5.size() <= 1, ERR & mo5, ERR & mu5}) begin
                errs++; $display("FAIL rand5 n=%0d got=%0d/%b want=%0d", n, cnt5, {full5, empty5, af5, ae5, ov5, un5}, q5.size()); end
            checks++; if (cnt3 !== 2'(q3.size()) || {full3, empty3, af3, ae3, ov3, un3} !== {q3.size() == 3, q3.size() == 0, q3.size() >= 2, q3.size() <= 1, ERR & mo3, ERR & mu3}) begin
                errs++; $display("FAIL rand3 n=%0d got=%0d/%b want=%0d", n, cnt3, {full3, empty3, af3, ae3, ov3, un3}, q3.size()); end
            if (q4.size() != 0) begin checks++; if (rd4 !== q4[0][7:0]) begin errs++; $display("FAIL rand4_data n=%0d got=%h want=%h", n, rd4, q4[0][7:0]); end end
            if (q5.size() != 0) begin checks++; if (rd5 !== q5[0]) begin errs++; $display("FAIL rand5_data n=%0d got=%h want=%h", n, rd5, q5[0]); end end
            if (q3.size() != 0) begin checks++; if (rd3 !== q3[0][7:0]) begin errs++; $display("FAIL rand3_data n=%0d got=%h want=%h", n, rd3, q3[0][7:0]); end end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_push_pop();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
